// File: rtl/scan_doubler.sv
// scan_doubler: line-doubles PET video into a 31 kHz stream; define SCANLINE_EN to blank the repeat line
module scan_doubler #(
    parameter int MAX_PIXELS = 512,
    parameter int H_SYNC_LEN = 61,
    parameter int PERIOD_W   = 11
) (
    input  logic clk16_i,
    input  logic reset_i,
    input  logic pixel_en_i,
    input  logic h_sync_i,
    input  logic v_sync_i,
    input  logic video_i,
    output logic h_sync_o,
    output logic v_sync_o,
    output logic video_o,
    output logic overflow_o
);
    localparam int AW = $clog2(MAX_PIXELS);
    localparam int CW = $clog2(MAX_PIXELS + 1);
    localparam logic [PERIOD_W-1:0] SAT = '1;

    logic mem [2][MAX_PIXELS];
    logic h_sync_q, wbank, armed, rep, rd_bit, rd_vld;
    logic [CW-1:0] wr_addr, rd_addr, line_len;
    logic [PERIOD_W-1:0] period_cnt, half_period, out_cnt;
    logic ils, mid, ols, wr, drop;

    // writes are ignored until the first line start after reset, so a partial line never reaches the buffer
    always_comb begin
        ils  = h_sync_q & ~h_sync_i;
        mid  = ~rep & (half_period != '0) & (out_cnt == half_period - PERIOD_W'(1));
        ols  = ils | mid;
        wr   = armed & pixel_en_i & ~ils & (wr_addr < CW'(MAX_PIXELS));
        drop = armed & pixel_en_i & ~ils & (wr_addr == CW'(MAX_PIXELS));
    end

    always_ff @(posedge clk16_i) begin
        if (wr) mem[wbank][wr_addr[AW-1:0]] <= video_i;
        rd_bit <= mem[~wbank][rd_addr[AW-1:0]];
    end

    always_ff @(posedge clk16_i) begin
        if (reset_i) begin
            h_sync_q    <= 1'b1;
            wbank       <= 1'b0;
            armed       <= 1'b0;
            rep         <= 1'b0;
            rd_vld      <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            line_len    <= '0;
            period_cnt  <= '0;
            half_period <= '0;
            out_cnt     <= '0;
            h_sync_o    <= 1'b1;
            v_sync_o    <= 1'b1;
            overflow_o  <= 1'b0;
        end else begin
            h_sync_q   <= h_sync_i;
            period_cnt <= ils ? '0 : (period_cnt == SAT ? period_cnt : period_cnt + PERIOD_W'(1));
            overflow_o <= overflow_o | drop;
            rd_vld     <= rd_addr < line_len;
            if (ils) begin
                wbank       <= ~wbank;
                wr_addr     <= '0;
                line_len    <= wr_addr;
                armed       <= 1'b1;
                half_period <= (armed && period_cnt != SAT) ? period_cnt >> 1 : '0;
            end else if (wr) begin
                wr_addr <= wr_addr + CW'(1);
            end
            if (ols) begin
                out_cnt  <= '0;
                rd_addr  <= '0;
                rep      <= ~ils;
                v_sync_o <= v_sync_i;
                h_sync_o <= 1'b0;
            end else begin
                out_cnt  <= out_cnt == SAT ? out_cnt : out_cnt + PERIOD_W'(1);
                rd_addr  <= rd_addr < line_len ? rd_addr + CW'(1) : rd_addr;
                h_sync_o <= h_sync_o | (out_cnt >= PERIOD_W'(H_SYNC_LEN - 1));
            end
        end
    end

`ifdef SCANLINE_EN
    assign video_o = rd_bit & rd_vld & h_sync_o & ~rep;
`else
    assign video_o = rd_bit & rd_vld & h_sync_o;
`endif
endmodule
